// File: rtl/fnd_pkg.sv
// fnd_pkg: shared state encoding and source constants for the FND display arbiter
package fnd_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, SHOW = 2'd1, ALERT = 2'd2} state_e;
    localparam logic [1:0] ALERT_SRC = 2'd3;
    localparam int NUM_NORMAL_SRC = 3;
endpackage

// File: rtl/fnd_display_arbiter_if.sv
// fnd_display_arbiter_if: source requests/values in, display value and selection out
interface fnd_display_arbiter_if;
    logic [3:0]  src_req;
    logic [15:0] src_value0;
    logic [15:0] src_value1;
    logic [15:0] src_value2;
    logic [15:0] src_value3;
    logic        btn_next;
    logic        auto_rotate;
    logic [15:0] fnd_value;
    logic        fnd_blank;
    logic [1:0]  sel_src;
    logic        sel_valid;
    modport master (
        output src_req, src_value0, src_value1, src_value2, src_value3, btn_next, auto_rotate,
        input  fnd_value, fnd_blank, sel_src, sel_valid
    );
    modport slave (
        input  src_req, src_value0, src_value1, src_value2, src_value3, btn_next, auto_rotate,
        output fnd_value, fnd_blank, sel_src, sel_valid
    );
endinterface

// File: rtl/fnd_rr_pick.sv
// fnd_rr_pick: next requesting normal source strictly after cur (wrapping 2->0), else cur itself
module fnd_rr_pick
    import fnd_pkg::*;
(
    input  logic [NUM_NORMAL_SRC-1:0] req,
    input  logic [1:0]                cur,
    output logic [1:0]                next,
    output logic                      found
);
    logic [3:0] req_x;
    logic [1:0] c1;
    logic [1:0] c2;
    assign req_x = {1'b0, req};
    assign c1    = (cur == 2'd2) ? 2'd0 : cur + 2'd1;
    assign c2    = (cur == 2'd0) ? 2'd2 : cur - 2'd1;
    assign found = req_x[c1] | req_x[c2] | req_x[cur];
    assign next  = req_x[c1] ? c1 : req_x[c2] ? c2 : cur;
endmodule

// File: rtl/fnd_display_arbiter.sv
// fnd_display_arbiter: shares the FND display between three rotating sources and a blinking alert source
module fnd_display_arbiter
    import fnd_pkg::*;
#(
    parameter int DWELL_CYCLES = 200_000_000,
    parameter int BLINK_HALF   = 25_000_000
) (
    input logic                  clk,
    input logic                  reset_n,
    fnd_display_arbiter_if.slave bus
);
    localparam int DW = $clog2(DWELL_CYCLES);
    localparam int BW = $clog2(BLINK_HALF);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_SHOW  = SHOW;
    localparam logic [1:0] S_ALERT = ALERT;

    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic [1:0]    cur;
    logic [1:0]    cur_nx;
    logic [1:0]    pick;
    logic          found;
    logic          cur_req;
    logic          adv;
    logic [DW-1:0] dwell_cnt;
    logic [DW-1:0] dwell_nx;
    logic [BW-1:0] blink_cnt;
    logic [15:0]   value_nx;

    fnd_rr_pick u_pick (
        .req  (bus.src_req[NUM_NORMAL_SRC-1:0]),
        .cur  (cur),
        .next (pick),
        .found(found)
    );

    assign cur_req = bus.src_req[cur];
    assign adv     = bus.btn_next || (bus.auto_rotate && dwell_cnt == DWELL_LAST) || !cur_req;

    // alert preempts everything; leaving alert prefers cur, otherwise IDLE/SHOW rotate through the picker
    always_comb begin
        state_nx = state;
        cur_nx   = cur;
        if (bus.src_req[ALERT_SRC]) begin
            state_nx = S_ALERT;
        end else if (state == S_ALERT) begin
            state_nx = (cur_req || found) ? S_SHOW : S_IDLE;
            cur_nx   = cur_req ? cur : pick;
        end else if (state == S_IDLE || adv) begin
            state_nx = found ? S_SHOW : S_IDLE;
            cur_nx   = pick;
        end
    end

    // dwell counter: frozen through alert, runs only while staying on a source with auto_rotate set
    always_comb begin
        dwell_nx = (state_nx == S_ALERT) ? dwell_cnt :
                   (state == S_SHOW && state_nx == S_SHOW && !adv && bus.auto_rotate) ? dwell_cnt + 1'b1 : '0;
        value_nx = (state_nx == S_ALERT) ? bus.src_value3 :
                   (state_nx == S_IDLE)  ? 16'h0000 :
                   (cur_nx == 2'd0)      ? bus.src_value0 :
                   (cur_nx == 2'd1)      ? bus.src_value1 : bus.src_value2;
    end

    // state, counters and registered display outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            cur           <= 2'd0;
            dwell_cnt     <= '0;
            blink_cnt     <= '0;
            bus.fnd_value <= 16'h0000;
            bus.fnd_blank <= 1'b1;
            bus.sel_src   <= 2'd0;
            bus.sel_valid <= 1'b0;
        end else begin
            state         <= state_nx;
            cur           <= cur_nx;
            dwell_cnt     <= dwell_nx;
            blink_cnt     <= (state == S_ALERT && state_nx == S_ALERT && blink_cnt != BLINK_LAST) ? blink_cnt + 1'b1 : '0;
            bus.fnd_blank <= (state_nx == S_IDLE) ? 1'b1 :
                             (state_nx == S_SHOW) ? 1'b0 :
                             (state == S_ALERT)   ? bus.fnd_blank ^ (blink_cnt == BLINK_LAST) : 1'b0;
            bus.fnd_value <= value_nx;
            bus.sel_src   <= (state_nx == S_ALERT) ? ALERT_SRC : (state_nx == S_SHOW) ? cur_nx : 2'd0;
            bus.sel_valid <= state_nx != S_IDLE;
        end
    end
endmodule
